// File: rtl/twiddle_seq_pkg.sv
// Shared definitions for the twiddle-factor sequencer: FSM state type,
// default geometry and the Q-format unity constant.
package twiddle_seq_pkg;

  localparam int N_DEF         = 256;
  localparam int ROM_WIDTH_DEF = 8;
  localparam int ADDRW_DEF     = $clog2(N_DEF);
  localparam int ONE           = 1 << ROM_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/twiddle_seq_exp.sv
// Exponent counter for one FFT stage: counts 0..N/2-1 and turns the count
// into sine/cosine lookup indices for the latched stage number.
module twiddle_exp_ctr
  import twiddle_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ADDRW = $clog2(N),
  parameter int SW    = $clog2(ADDRW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [SW-1:0]    stage,
  output logic [ADDRW-1:0] sin_id,
  output logic [ADDRW-1:0] cos_id,
  output logic             last
);

  localparam int CW = ADDRW - 1;

  logic [CW-1:0]    c;
  logic [ADDRW-1:0] mask;
  logic [ADDRW-1:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
    end else if (clr) begin
      c <= '0;
    end else if (inc) begin
      c <= c + 1'b1;
    end
  end

  // Stage s repeats a pattern of N>>(s+1) exponents spaced 2^s apart.
  always_comb begin
    mask   = ADDRW'((N >> (int'(stage) + 1)) - 1);
    k      = {1'b0, c} & mask;
    sin_id = k << stage;
    cos_id = sin_id + ADDRW'(N / 4);
    last   = (c == CW'(N / 2 - 1));
  end

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle sequencer top: frame FSM, valid/ready output register holding
// W = cos - j*sin. Optional macro TWIDDLE_SEQ_INVERSE_EN adds an 'inverse'
// input selecting conjugate twiddles (cos + j*sin) for IFFT frames.
module twiddle_seq
  import twiddle_seq_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int ROM_WIDTH = ROM_WIDTH_DEF,
  parameter int ADDRW     = $clog2(N),
  parameter int SW        = $clog2(ADDRW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SW-1:0]          stage,
`ifdef TWIDDLE_SEQ_INVERSE_EN
  input  logic                   inverse,
`endif
  output logic [ADDRW-1:0]       sin_id,
  output logic [ADDRW-1:0]       cos_id,
  input  logic [2*ROM_WIDTH-1:0] sin_data,
  input  logic [2*ROM_WIDTH-1:0] cos_data,
  output logic [2*ROM_WIDTH-1:0] tw_re,
  output logic [2*ROM_WIDTH-1:0] tw_im,
  output logic                   tw_valid,
  input  logic                   tw_ready,
  output logic                   tw_last,
  output logic                   busy,
  output logic                   done,
  output state_e                 dbg_state
);

  // Stream handshake: a twiddle transfers on a rising edge where tw_valid
  // and tw_ready are both high; while tw_valid is high and tw_ready low,
  // tw_re/tw_im/tw_last are held unchanged.

  state_e        state;
  state_e        state_nxt;
  logic [SW-1:0] stage_q;
  logic          inv_q;
  logic          load;
  logic          accept;
  logic          start_ok;
  logic          flush_done;
  logic          c_last;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)           state_nxt = ST_RUN;
      ST_RUN:   if (load && c_last)  state_nxt = ST_FLUSH;
      ST_FLUSH: if (accept)          state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    accept     = tw_valid && tw_ready;
    load       = (state == ST_RUN) && (!tw_valid || tw_ready);
    start_ok   = (state == ST_IDLE) && start;
    flush_done = (state == ST_FLUSH) && accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (start_ok) begin
      stage_q <= (int'(stage) >= ADDRW) ? SW'(ADDRW - 1) : stage;
    end
  end

`ifdef TWIDDLE_SEQ_INVERSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (start_ok) begin
      inv_q <= inverse;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_re    <= '0;
      tw_im    <= '0;
      tw_last  <= 1'b0;
      tw_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= flush_done;
      if (load) begin
        tw_re    <= cos_data;
        tw_im    <= inv_q ? sin_data : -sin_data;
        tw_last  <= c_last;
        tw_valid <= 1'b1;
      end else if (tw_ready) begin
        tw_valid <= 1'b0;
      end
    end
  end

  twiddle_exp_ctr #(
    .N     (N),
    .ADDRW (ADDRW),
    .SW    (SW)
  ) u_exp (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush_done),
    .inc    (load),
    .stage  (stage_q),
    .sin_id (sin_id),
    .cos_id (cos_id),
    .last   (c_last)
  );

endmodule

// File: tb/tb_twiddle_seq.sv
// Self-checking bench for twiddle_seq: sine ROM model, scoreboard on the
// twiddle stream, constant vectors for known angles, randomized frames.
module tb_twiddle_seq;
  import twiddle_seq_pkg::*;

  localparam int N  = 256;
  localparam int RW = 8;
  localparam int AW = 8;
  localparam int SW = 3;
  localparam int DW = 2 * RW;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [SW-1:0]        stage;
`ifdef TWIDDLE_SEQ_INVERSE_EN
  logic                 inverse;
`endif
  logic [AW-1:0]        sin_id;
  logic [AW-1:0]        cos_id;
  logic signed [DW-1:0] sin_data;
  logic signed [DW-1:0] cos_data;
  logic signed [DW-1:0] tw_re;
  logic signed [DW-1:0] tw_im;
  logic                 tw_valid;
  logic                 tw_ready;
  logic                 tw_last;
  logic                 busy;
  logic                 done;
  state_e               dbg_state;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] rom [N];
  logic [2*DW:0]        exp_q[$];
  int                   acc_cnt;
  int                   capt_re [N/2];
  int                   capt_im [N/2];

  twiddle_seq #(.N(N), .ROM_WIDTH(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stage     (stage),
`ifdef TWIDDLE_SEQ_INVERSE_EN
    .inverse   (inverse),
`endif
    .sin_id    (sin_id),
    .cos_id    (cos_id),
    .sin_data  (sin_data),
    .cos_data  (cos_data),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_last   (tw_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Full-cycle sine lookups, combinational.
  assign sin_data = rom[sin_id];
  assign cos_data = rom[cos_id];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int round_sin(input int i);
    real v;
    v = $sin(6.283185307179586 * real'(i) / real'(N)) * real'(ONE);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Reference: exponent e = (c mod period) * 2^s, W = cos(e) -/+ j sin(e).
  function automatic logic [2*DW:0] model(input int c, input int s, input bit inv);
    int span;
    int e;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] sn;
    logic signed [DW-1:0] im;
    span = N / (2 ** (s + 1));
    e    = (c % span) * (2 ** s);
    re   = rom[(e + N / 4) % N];
    sn   = rom[e];
    im   = inv ? sn : -sn;
    return {(c == N / 2 - 1), re, im};
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  bit                   hold_pend;
  bit                   exp_done;
  logic signed [DW-1:0] h_re;
  logic signed [DW-1:0] h_im;
  logic                 h_last;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
      exp_done  = 0;
    end else begin
      logic [2*DW:0] e;
      check_eq("done_pulse", done, exp_done);
      exp_done = 0;
      if (hold_pend) begin
        check_eq("hold_valid", tw_valid, 1);
        check_eq("hold_re", tw_re, h_re);
        check_eq("hold_im", tw_im, h_im);
        check_eq("hold_last", tw_last, h_last);
      end
      hold_pend = tw_valid && !tw_ready;
      h_re = tw_re;
      h_im = tw_im;
      h_last = tw_last;
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_twiddle", acc_cnt, -1);
        end else begin
          e = exp_q.pop_front();
          check_eq("tw_re", tw_re, $signed(e[2*DW-1:DW]));
          check_eq("tw_im", tw_im, $signed(e[DW-1:0]));
          check_eq("tw_last", tw_last, e[2*DW]);
          exp_done = e[2*DW];
        end
        if (acc_cnt < N / 2) begin
          capt_re[acc_cnt] = tw_re;
          capt_im[acc_cnt] = tw_im;
        end
        acc_cnt++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_tw_valid"}, tw_valid, 0);
    check_eq({tag, "_tw_re"}, tw_re, 0);
    check_eq({tag, "_tw_im"}, tw_im, 0);
    check_eq({tag, "_tw_last"}, tw_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_sin_id"}, sin_id, 0);
    check_eq({tag, "_cos_id"}, cos_id, N / 4);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low 5 cycles at 3rd output.
  task automatic run_frame(input int s, input bit inv, input int mode,
                           input int poke, input int abort_at);
    bit seen_done;
    bit aborted;
    int stall;
    exp_q.delete();
    acc_cnt = 0;
    for (int c = 0; c < N / 2; c++) exp_q.push_back(model(c, s, inv));
    @(posedge clk); #1;
    start = 1'b1;
    stage = SW'(s);
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = inv;
`endif
    tw_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stage = SW'(s ^ 1);
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = ~inv;
`endif
    check_eq("busy_after_start", busy, 1);
    check_eq("valid_at_start_edge", tw_valid, 0);
    seen_done = 0;
    aborted = 0;
    stall = 0;
    for (int cyc = 0; cyc < 8 * N && !seen_done && !aborted; cyc++) begin
      if (mode == 1) tw_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && acc_cnt == 2 && stall < 5) begin
        tw_ready = 1'b0;
        stall++;
      end else tw_ready = 1'b1;
      start = (cyc == poke);
      if (cyc == poke) stage = SW'((s + 3) % 8);
      @(posedge clk); #1;
      if (cyc == 0) check_eq("first_valid", tw_valid, 1);
      if (abort_at >= 0 && acc_cnt == abort_at) begin
        rst = 1'b1;
        aborted = 1;
      end
      if (done) seen_done = 1;
    end
    start = 1'b0;
    tw_ready = 1'b1;
    if (!aborted) begin
      check_eq("frame_done_seen", seen_done, 1);
      check_eq("frame_count", acc_cnt, N / 2);
      check_eq("exp_q_empty", exp_q.size(), 0);
    end
  endtask

  typedef struct {
    int s;
    int c;
    int re;
    int im;
  } vec_t;

  vec_t vt[9];

  task automatic check_table(input int s);
    foreach (vt[i]) begin
      if (vt[i].s == s) begin
        check_eq($sformatf("vec_s%0d_c%0d_re", s, vt[i].c), capt_re[vt[i].c], vt[i].re);
        check_eq($sformatf("vec_s%0d_c%0d_im", s, vt[i].c), capt_im[vt[i].c], vt[i].im);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = DW'(round_sin(i));
    vt[0] = '{0, 0,   256,  0};
    vt[1] = '{0, 64,  0,    -256};
    vt[2] = '{0, 32,  181,  -181};
    vt[3] = '{0, 127, -256, -6};
    vt[4] = '{7, 0,   256,  0};
    vt[5] = '{7, 100, 256,  0};
    vt[6] = '{6, 1,   0,    -256};
    vt[7] = '{6, 2,   256,  0};
    vt[8] = '{6, 127, 0,    -256};

    rst = 1'b1;
    start = 1'b0;
    stage = '0;
    tw_ready = 1'b1;
    acc_cnt = 0;
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    run_frame(0, 0, 0, -1, -1);
    check_table(0);
    run_frame(7, 0, 0, -1, -1);
    check_table(7);
    run_frame(6, 0, 0, -1, -1);
    check_table(6);

    run_frame(6, 0, 2, -1, -1);
    check_table(6);

    run_frame(3, 0, 0, 10, -1);

    run_frame(2, 0, 0, -1, 40);
    @(negedge clk);
    check_reset_vals("mid_rst");
    exp_q.delete();
    #2 rst = 1'b0;
    run_frame(0, 0, 0, -1, -1);
    check_table(0);

`ifdef TWIDDLE_SEQ_INVERSE_EN
    run_frame(6, 1, 0, -1, -1);
    check_eq("inv_c0_re", capt_re[0], 256);
    check_eq("inv_c0_im", capt_im[0], 0);
    check_eq("inv_c1_re", capt_re[1], 0);
    check_eq("inv_c1_im", capt_im[1], 256);
`endif

    for (int f = 0; f < 6; f++) begin
      int s;
      bit inv;
      s = $urandom_range(0, 7);
      inv = 1'b0;
`ifdef TWIDDLE_SEQ_INVERSE_EN
      inv = 1'($urandom_range(0, 1));
`endif
      run_frame(s, inv, 1, $urandom_range(0, 60), -1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
